// File: rtl/jt12_multi_acc.sv
// Time-multiplexed saturating accumulator: CH channels x OPS operators, one shared adder, plus a frame mix.
// Optional macro JT12_ACC_CLIP_FLAG_EN adds snd_clip/mix_clip saturation flags.
module jt12_multi_acc #(
    parameter int WIN  = 14,
    parameter int WOUT = 16,
    parameter int CH   = 6,
    parameter int OPS  = 4,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
    localparam int OPW = $clog2(OPS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic signed [WIN-1:0]  op_result,
    input  logic                   sum_en,
    input  logic                   zero,
    output logic signed [WOUT-1:0] snd,
    output logic [CHW-1:0]         snd_ch,
    output logic                   snd_valid,
    output logic signed [WOUT-1:0] mix,
`ifdef JT12_ACC_CLIP_FLAG_EN
    output logic                   snd_clip,
    output logic                   mix_clip,
`endif
    output logic                   mix_valid
);

    localparam logic [CHW-1:0] CH_LAST = CHW'(CH - 1);
    localparam logic [OPW-1:0] OP_LAST = OPW'(OPS - 1);

    // Returns {overflow, saturated sum}; rail chosen by the sign of the running value a.
    function automatic logic [WOUT:0] sat_add(input logic signed [WOUT-1:0] a,
                                              input logic signed [WOUT-1:0] b);
        logic signed [WOUT-1:0] s;
        logic                   ovf;
        s   = a + b;
        ovf = (a[WOUT-1] == b[WOUT-1]) && (s[WOUT-1] != a[WOUT-1]);
        if (ovf)
            s = a[WOUT-1] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
        return {ovf, s};
    endfunction

    // cnt is kept as (op, ch) so the slot mapping needs no divider.
    logic [CHW-1:0]         ch_q, ch_d, cur_ch;
    logic [OPW-1:0]         op_q, op_d, cur_op;
    logic signed [WOUT-1:0] acc_q [CH];
    logic signed [WOUT-1:0] mix_acc_q;
    logic                   frame_ok_q;
    logic signed [WOUT-1:0] snd_q, mix_q;
    logic [CHW-1:0]         snd_ch_q;
    logic                   snd_valid_q, mix_valid_q;

    logic signed [WOUT-1:0] cur, acc_cur, ch_res_d, mix_res_d;
    logic                   ch_ovf, mx_ovf;
    logic signed [WOUT-1:0] ch_sum, mx_sum;

    always_comb begin
        cur_ch  = zero ? '0 : ch_q;
        cur_op  = zero ? '0 : op_q;
        ch_d    = cur_ch + 1'b1;
        op_d    = cur_op;
        if (cur_ch == CH_LAST) begin
            ch_d = '0;
            op_d = (cur_op == OP_LAST) ? '0 : cur_op + 1'b1;
        end
        cur     = sum_en ? {{(WOUT-WIN){op_result[WIN-1]}}, op_result} : '0;
        acc_cur = acc_q[cur_ch];
        {ch_ovf, ch_sum} = sat_add(acc_cur, cur);
        ch_res_d = (cur_op == '0) ? cur : ch_sum;
        {mx_ovf, mx_sum} = sat_add(mix_acc_q, ch_res_d);
        mix_res_d = (cur_ch == '0) ? ch_res_d : mx_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            op_q        <= '0;
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
            mix_acc_q   <= '0;
            frame_ok_q  <= 1'b0;
            snd_q       <= '0;
            snd_ch_q    <= '0;
            mix_q       <= '0;
            snd_valid_q <= 1'b0;
            mix_valid_q <= 1'b0;
        end else begin
            snd_valid_q <= 1'b0;
            mix_valid_q <= 1'b0;
            if (clk_en) begin
                ch_q          <= ch_d;
                op_q          <= op_d;
                acc_q[cur_ch] <= ch_res_d;
                if (cur_ch == '0 && cur_op == '0)
                    frame_ok_q <= 1'b1;
                if (cur_op == OP_LAST) begin
                    snd_q       <= ch_res_d;
                    snd_ch_q    <= cur_ch;
                    snd_valid_q <= 1'b1;
                    mix_acc_q   <= mix_res_d;
                    if (cur_ch == CH_LAST && frame_ok_q) begin
                        mix_q       <= mix_res_d;
                        mix_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef JT12_ACC_CLIP_FLAG_EN
    logic [CH-1:0] clip_q;
    logic          mclip_acc_q, snd_clip_q, mix_clip_q;
    logic          ch_clip_d, mclip_d;

    always_comb begin
        ch_clip_d = (cur_op != '0) && (clip_q[cur_ch] || ch_ovf);
        mclip_d   = (cur_ch == '0) ? ch_clip_d : (mclip_acc_q || ch_clip_d || mx_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q      <= '0;
            mclip_acc_q <= 1'b0;
            snd_clip_q  <= 1'b0;
            mix_clip_q  <= 1'b0;
        end else if (clk_en) begin
            clip_q[cur_ch] <= ch_clip_d;
            if (cur_op == OP_LAST) begin
                snd_clip_q  <= ch_clip_d;
                mclip_acc_q <= mclip_d;
                if (cur_ch == CH_LAST && frame_ok_q)
                    mix_clip_q <= mclip_d;
            end
        end
    end

    assign snd_clip = snd_clip_q;
    assign mix_clip = mix_clip_q;
`endif

    assign snd       = snd_q;
    assign snd_ch    = snd_ch_q;
    assign snd_valid = snd_valid_q;
    assign mix       = mix_q;
    assign mix_valid = mix_valid_q;

endmodule

// File: tb/tb_jt12_multi_acc.sv
// Randomized bench for jt12_multi_acc against an integer-arithmetic frame model.
// Also checks snd_clip/mix_clip when built with JT12_ACC_CLIP_FLAG_EN.
module tb_jt12_multi_acc;

    localparam int WIN  = 14;
    localparam int WOUT = 16;
    localparam int CH   = 6;
    localparam int OPS  = 4;
    localparam int NS   = CH * OPS;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clk_en = 1'b0;
    logic                   sum_en = 1'b0;
    logic                   zero = 1'b0;
    logic signed [WIN-1:0]  op_result = '0;
    logic signed [WOUT-1:0] snd, mix;
    logic [2:0]             snd_ch;
    logic                   snd_valid, mix_valid;
`ifdef JT12_ACC_CLIP_FLAG_EN
    logic                   snd_clip, mix_clip;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jt12_multi_acc #(.WIN(WIN), .WOUT(WOUT), .CH(CH), .OPS(OPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .op_result (op_result),
        .sum_en    (sum_en),
        .zero      (zero),
        .snd       (snd),
        .snd_ch    (snd_ch),
        .snd_valid (snd_valid),
        .mix       (mix),
`ifdef JT12_ACC_CLIP_FLAG_EN
        .snd_clip  (snd_clip),
        .mix_clip  (mix_clip),
`endif
        .mix_valid (mix_valid)
    );

    // Reference model: slot number, per-channel integer sums clamped to the output range.
    int m_slot;
    int m_acc [CH];
    bit m_clip [CH];
    int m_mix;
    bit m_mclip;
    bit m_fok;
    int e_snd, e_ch, e_mix;
    bit e_sv, e_mv, e_sclip, e_mclip;

    function automatic bit out_of_range(input int v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic int clampv(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    task automatic model_reset();
        m_slot = 0; m_mix = 0; m_mclip = 0; m_fok = 0;
        for (int i = 0; i < CH; i++) begin m_acc[i] = 0; m_clip[i] = 0; end
        e_snd = 0; e_ch = 0; e_mix = 0;
        e_sv = 0; e_mv = 0; e_sclip = 0; e_mclip = 0;
    endtask

    task automatic model_edge(input bit en, input bit z, input bit sen, input int opv);
        int s, ch, op, cur, sum;
        e_sv = 0;
        e_mv = 0;
        if (!en) return;
        s   = z ? 0 : m_slot;
        ch  = s % CH;
        op  = s / CH;
        cur = sen ? opv : 0;
        if (s == 0) m_fok = 1;
        if (op == 0) begin
            m_acc[ch]  = cur;
            m_clip[ch] = 0;
        end else begin
            sum = m_acc[ch] + cur;
            if (out_of_range(sum)) m_clip[ch] = 1;
            m_acc[ch] = clampv(sum);
        end
        if (op == OPS - 1) begin
            e_snd = m_acc[ch]; e_ch = ch; e_sv = 1; e_sclip = m_clip[ch];
            if (ch == 0) begin
                m_mix   = m_acc[ch];
                m_mclip = m_clip[ch];
            end else begin
                sum     = m_mix + m_acc[ch];
                m_mclip = m_mclip | m_clip[ch] | out_of_range(sum);
                m_mix   = clampv(sum);
            end
            if (ch == CH - 1 && m_fok) begin
                e_mix = m_mix; e_mv = 1; e_mclip = m_mclip;
            end
        end
        m_slot = (s + 1) % NS;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("snd_valid", int'(snd_valid), int'(e_sv));
        chk("mix_valid", int'(mix_valid), int'(e_mv));
        chk("snd", int'(snd), e_snd);
        chk("snd_ch", int'(snd_ch), e_ch);
        chk("mix", int'(mix), e_mix);
`ifdef JT12_ACC_CLIP_FLAG_EN
        chk("snd_clip", int'(snd_clip), int'(e_sclip));
        chk("mix_clip", int'(mix_clip), int'(e_mclip));
`endif
    endtask

    task automatic step(input bit en, input bit z, input bit sen, input int opv);
        @(negedge clk);
        clk_en    = en;
        zero      = z;
        sum_en    = sen;
        op_result = WIN'(opv);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(en, z, sen, opv);
        #1 check_outputs();
    endtask

    task automatic frame_const(input int v);
        for (int s = 0; s < NS; s++) step(1'b1, s == 0, 1'b1, v);
    endtask

    function automatic int rand_op();
        case ($urandom_range(0, 3))
            0:       return 8191;
            1:       return -8192;
            default: return int'($urandom_range(0, 16383)) - 8192;
        endcase
    endfunction

    initial begin
        model_reset();
        // Held in reset with activity on the inputs.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'b1, rand_op());
        clk_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running start after reset, zero held low.
        for (int s = 0; s < NS + 3; s++) step(1'b1, 1'b0, 1'b1, 50);

        frame_const(100);
        frame_const(100);
        frame_const(8191);
        frame_const(-8192);

        // sum_en dropped on ch2 ops 1..3.
        for (int s = 0; s < NS; s++)
            step(1'b1, s == 0, !((s % CH == 2) && (s / CH > 0)), 500);

        // ch1 driven to the rail and back.
        for (int s = 0; s < NS; s++)
            step(1'b1, s == 0, 1'b1, (s == 1) ? -8192 : 8191);

        // Aborted frame then a full one.
        for (int s = 0; s < 10; s++) step(1'b1, s == 0, 1'b1, 300);
        frame_const(77);
        for (int s = 0; s < 20; s++) step(1'b1, s == 0, 1'b1, -400);
        frame_const(1234);

        // clk_en active one cycle in three.
        for (int s = 0; s < NS; s++) begin
            step(1'b1, s == 0, 1'b1, rand_op());
            step(1'b0, 1'b0, 1'b1, rand_op());
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1, rand_op());
        end

        // Random traffic with occasional frame restarts.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 7) != 0, rand_op());

        // Asynchronous reset in the middle of a frame.
        for (int s = 0; s < 7; s++) step(1'b1, s == 0, 1'b1, 2000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        step(1'b1, 1'b0, 1'b1, 999);
        step(1'b1, 1'b1, 1'b1, 999);
        clk_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        frame_const(-3000);
        frame_const(2500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
